// File: rtl/fir_pkg.sv
// Shared types and constants for the fir_mac_p time-multiplexed FIR.
// State enum, default coefficient table, rounding constant, ACC_W helper.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Accumulator wide enough that TAPS full-precision products never wrap.
  function automatic int acc_width(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  // Default table: h[0] = largest positive Q(cw-1) value, rest zero,
  // which makes the filter a pass-through of the newest sample.
  function automatic longint def_coef(
    input int k,
    input int cw
  );
    if (k == 0)
      return (64'sd1 <<< (cw - 1)) - 64'sd1;
    return 64'sd0;
  endfunction

  // Half an LSB of the output scale, added before the Q shift.
  function automatic longint round_const(
    input int cw
  );
    return 64'sd1 <<< (cw - 2);
  endfunction

endpackage

// File: rtl/fir_coef_store.sv
// Coefficient store h[0..TAPS-1] with a combinational read at tap k.
// Ports: k (read index), coef (h[k]); with FIR_COEF_LOAD_EN also
// clk, reset, we, addr, din for run-time writes (reset reloads table).
module fir_coef_store
  import fir_pkg::*;
#(
  parameter int TAPS   = 32,
  parameter int COEF_W = 16
) (
`ifdef FIR_COEF_LOAD_EN
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [$clog2(TAPS)-1:0] addr,
  input  logic [COEF_W-1:0]       din,
`endif
  input  logic [$clog2(TAPS)-1:0] k,
  output logic [COEF_W-1:0]       coef
);

  logic [COEF_W-1:0] h [TAPS];

`ifdef FIR_COEF_LOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++)
        h[i] <= COEF_W'(def_coef(i, COEF_W));
    end else if (we) begin
      h[addr] <= din;
    end
  end
`else
  for (genvar i = 0; i < TAPS; i++) begin : g_rom
    assign h[i] = COEF_W'(def_coef(i, COEF_W));
  end
`endif

  assign coef = h[k];

endmodule

// File: rtl/fir_mac_p.sv
// Parametrised single-multiplier FIR: one MAC per clock over TAPS taps.
// Ports: clk, reset (async high), sample/xIn in; yOut/yValid/busy/overrun
// out. FIR_COEF_LOAD_EN adds coef_we/coef_addr/coef_din writes (idle only).
module fir_mac_p
  import fir_pkg::*;
#(
  parameter int TAPS   = 32,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample,
  input  logic [DATA_W-1:0]       xIn,
`ifdef FIR_COEF_LOAD_EN
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_din,
`endif
  output logic [DATA_W-1:0]       yOut,
  output logic                    yValid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int KW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] RND =
    ACC_W'(round_const(COEF_W));
  localparam logic signed [ACC_W-1:0] YMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] YMIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t state;
  state_t state_nx;

  logic [KW-1:0]            k;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [COEF_W-1:0]        h_raw;
  logic signed [COEF_W-1:0] h;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  acc_sh;
  logic [DATA_W-1:0]        y_sat;
  logic                     last;

`ifdef FIR_COEF_LOAD_EN
  logic coef_wr;

  // Writes during a convolution would corrupt it; drop them.
  assign coef_wr = coef_we && (state == IDLE);
`endif

  fir_coef_store #(
    .TAPS  (TAPS),
    .COEF_W(COEF_W)
  ) u_coef (
`ifdef FIR_COEF_LOAD_EN
    .clk  (clk),
    .reset(reset),
    .we   (coef_wr),
    .addr (coef_addr),
    .din  (coef_din),
`endif
    .k    (k),
    .coef (h_raw)
  );

  assign h    = $signed(h_raw);
  assign last = (k == KW'(TAPS - 1));
  assign prod = x[k] * h;

  assign prod_ext =
    {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Round half up, then drop the Q(COEF_W-1) fraction.
  assign acc_rnd = acc + RND;
  assign acc_sh  = acc_rnd >>> (COEF_W - 1);

  always_comb begin
    y_sat = acc_sh[DATA_W-1:0];
    if (acc_sh > YMAX)
      y_sat = YMAX[DATA_W-1:0];
    else if (acc_sh < YMIN)
      y_sat = YMIN[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sample) state_nx = MAC;
      MAC:     if (last) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++)
        x[i] <= '0;
      acc     <= '0;
      k       <= '0;
      yOut    <= '0;
      yValid  <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      yValid <= 1'b0;
      if (sample && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (sample) begin
            for (int i = TAPS - 1; i > 0; i--)
              x[i] <= x[i-1];
            x[0] <= $signed(xIn);
            acc  <= '0;
            k    <= '0;
            busy <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 1'b1;
        end
        OUT: begin
          yOut   <= y_sat;
          yValid <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
